note_tone_gen: RTL and testbench
================================

Name: note_tone_gen

Overview:
- Downstream stage of the piano note decoder. Consumes the 4-bit note code that the decoder produces from the switches.
- Produces the square-wave FREQ output that drives the speaker pin.
- Per-note half-period counter.
- Note changes are applied only at half-period boundaries, so the output has no glitches or runt pulses.
- Provides status outputs (active, current note, toggle strobe) for the LED and game FSMs.

Parameters:
- CLK_HZ, 100000000, system clock frequency in Hz.
- CNT_W, 18, half-period counter width. Must hold CLK_HZ/(2*262).

Ports:
- CLK  input  1  system clock, rising edge.
- RESET  input  1  asynchronous, active-high reset.
- note  input  4  note code, synchronous to CLK: 0=none, 1=C, 2=D, 3=E, 4=F, 5=G, 6=A, 7=B, 8=C5. Codes 9-15 are treated as none.
- enable  input  1  0 forces silence at the next boundary; 1 allows playing.
- FREQ  output  1  square wave to the speaker.
- active  output  1  1 while a tone is being generated.
- cur_note  output  4  note code currently sounding (0 when silent).
- tick  output  1  one-cycle pulse on each FREQ toggle.

Behaviour:
- Reset values: FREQ=0, active=0, cur_note=0, tick=0, counter=0, pending=0.
- Note frequencies in Hz: C 262, D 294, E 330, F 349, G 392, A 440, B 494, C5 523.
- HALF(n) = CLK_HZ/(2*f), integer division, evaluated at elaboration.
- HALF values at default CLK_HZ: C 190839, D 170068, E 151515, F 143266, G 127551, A 113636, B 101214, C5 95602.
- Input register: note and enable are registered once. pending = (enable && note in 1..8) ? note : 0. Latency from input to pending is 1 cycle.
- IDLE state (active=0, FREQ=0):
  - If pending != 0, the next cycle enters PLAY with cur_note=pending, counter=HALF(pending)-1, FREQ=1, tick=1.
  - Total latency from note input to FREQ rising is 2 cycles.
- PLAY state: the counter decrements each cycle.
  - When counter==0: tick=1 for that cycle, FREQ toggles, and the boundary rule below applies.
  - Boundary, pending==cur_note: reload with HALF(cur_note)-1.
  - Boundary, pending is a different nonzero note: cur_note<=pending, reload with HALF(pending)-1. The FREQ toggle still happens.
  - Boundary, pending==0 and FREQ is about to go 1->0: go to IDLE, active<=0, cur_note<=0.
  - Boundary, pending==0 and FREQ is about to go 0->1: FREQ stays 0, no tick, go to IDLE. Every high phase is therefore completed, and no partial high pulse is ever produced.
- Note changes between boundaries are ignored. Only the pending value present at the boundary cycle matters.
- Every half-period is at least HALF(n) cycles, so no runt pulses occur.
- Invalid codes 9-15 behave exactly like note=0.
- enable falling mid-tone: treated as pending=0 at the next boundary.
- RESET mid-tone: all outputs clear immediately, asynchronously. After release the block starts from IDLE.
- Counter arithmetic is unsigned CNT_W-bit. The block never underflows, because it reloads on 0.

Optional Feature:
- Macro: TONE_OCTAVE_EN.
- When defined:
  - Adds input port oct, width 2.
  - oct is registered together with note.
  - Effective reload value is (HALF(n) >> oct) - 1, so oct=1 gives one octave up and oct=3 gives three octaves up.
  - An oct change is applied only at a boundary, with the same rule as a note change.
- When undefined: port oct is absent and behaviour is identical to oct=0.

Test Plan:
All scenarios use CLK_HZ=10000, CNT_W=8. At this setting HALF(C)=19, E=15, A=11, C5=9.
- Reset, then note=1 held: FREQ rises 2 cycles after note is applied, toggles every 19 cycles, active=1, cur_note=1, and tick pulses once per toggle.
- Playing C, switch to note=3 (E) mid half-period: the current 19-cycle half-period completes, then half-periods are 15 cycles and cur_note=3 from that boundary on. No half-period is shorter than 15 cycles.
- Playing A, note=0 during a high phase: high lasts the full 11 cycles, then FREQ=0, active=0, cur_note=0, tick stops. With note=0 during a low phase: low completes and FREQ stays 0.
- note=12 from IDLE: FREQ stays 0 and active stays 0. Then note=8: half-periods are 9 cycles.
- Playing E, enable=0: silence at the next boundary. enable=1 again: restarts with FREQ=1 after 2 cycles.
- RESET asserted mid-high phase: FREQ, active, cur_note and tick go to 0 without waiting for a clock edge. After release with note=1 held, normal start in 2 cycles.
- With TONE_OCTAVE_EN, note=1 and oct=1: half-periods are 9 cycles ((19>>1)).

Source files
------------

// File: rtl/note_tone_gen_if.sv
// rtl/note_tone_gen_if.sv - note/enable request and tone status bundle for note_tone_gen
//
// Purpose: groups the note request inputs and the tone outputs of note_tone_gen.
//   master : the note source side (decoder / testbench); drives the note request, reads status.
//   slave  : the tone generator side.
// Signals:
//   note     [3:0] note code, 0=none, 1..8 = C D E F G A B C5, 9..15 treated as none
//   enable         0 silences at the next half-period boundary
//   oct      [1:0] octave shift, present only when TONE_OCTAVE_EN is defined
//   FREQ           square wave to the speaker
//   active         1 while a tone is being generated
//   cur_note [3:0] note code currently sounding, 0 when silent
//   tick           one-cycle pulse on each FREQ toggle
interface note_tone_gen_if;
  logic [3:0] note;
  logic       enable;
`ifdef TONE_OCTAVE_EN
  logic [1:0] oct;
`endif
  logic       FREQ;
  logic       active;
  logic [3:0] cur_note;
  logic       tick;

`ifdef TONE_OCTAVE_EN
  modport master (output note, enable, oct, input FREQ, active, cur_note, tick);
  modport slave  (input note, enable, oct, output FREQ, active, cur_note, tick);
`else
  modport master (output note, enable, input FREQ, active, cur_note, tick);
  modport slave  (input note, enable, output FREQ, active, cur_note, tick);
`endif
endinterface

// File: rtl/note_tone_gen.sv
// rtl/note_tone_gen.sv - glitch-free square-wave note generator with boundary-aligned note changes
//
// Purpose: turns the decoder's note code into a square wave on FREQ. Each note has
//   its own half-period HALF(n) = CLK_HZ/(2*f). Note, enable and octave changes
//   are only taken at half-period boundaries, so no runt pulses are produced.
// Optional feature macro: TONE_OCTAVE_EN adds bus.oct; reload becomes (HALF(n) >> oct) - 1.
// Ports:
//   CLK   system clock, rising edge
//   RESET asynchronous active-high reset
//   bus   note_tone_gen_if.slave: note/enable(/oct) in, FREQ/active/cur_note/tick out
module note_tone_gen #(
  parameter int CLK_HZ = 100000000,
  parameter int CNT_W  = 18
) (
  input  logic            CLK,
  input  logic            RESET,
  note_tone_gen_if.slave  bus
);

  localparam logic [CNT_W-1:0] HALF_C  = CNT_W'(CLK_HZ / (2 * 262));
  localparam logic [CNT_W-1:0] HALF_D  = CNT_W'(CLK_HZ / (2 * 294));
  localparam logic [CNT_W-1:0] HALF_E  = CNT_W'(CLK_HZ / (2 * 330));
  localparam logic [CNT_W-1:0] HALF_F  = CNT_W'(CLK_HZ / (2 * 349));
  localparam logic [CNT_W-1:0] HALF_G  = CNT_W'(CLK_HZ / (2 * 392));
  localparam logic [CNT_W-1:0] HALF_A  = CNT_W'(CLK_HZ / (2 * 440));
  localparam logic [CNT_W-1:0] HALF_B  = CNT_W'(CLK_HZ / (2 * 494));
  localparam logic [CNT_W-1:0] HALF_C5 = CNT_W'(CLK_HZ / (2 * 523));

  typedef enum logic {IDLE, PLAY} state_t;

  state_t           state;
  logic [3:0]       pending;
  logic [1:0]       oct_q;
  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] span;
  logic [CNT_W-1:0] reload;
  logic             note_ok;

  function automatic logic [CNT_W-1:0] half_of(input logic [3:0] n);
    case (n)
      4'd1:    half_of = HALF_C;
      4'd2:    half_of = HALF_D;
      4'd3:    half_of = HALF_E;
      4'd4:    half_of = HALF_F;
      4'd5:    half_of = HALF_G;
      4'd6:    half_of = HALF_A;
      4'd7:    half_of = HALF_B;
      4'd8:    half_of = HALF_C5;
      default: half_of = '0;
    endcase
  endfunction

  assign note_ok = (bus.note != 4'd0) && (bus.note <= 4'd8);

`ifdef TONE_OCTAVE_EN
  // Octave is registered alongside the note so both land in the same cycle.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) oct_q <= 2'd0;
    else       oct_q <= bus.oct;
  end
`else
  assign oct_q = 2'd0;
`endif

  // Reload value for the pending note; a shifted span of 0 is clamped so the
  // counter can never wrap.
  always_comb begin
    span   = half_of(pending) >> oct_q;
    reload = (span == '0) ? '0 : span - CNT_W'(1);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state        <= IDLE;
      pending      <= 4'd0;
      counter      <= '0;
      bus.FREQ     <= 1'b0;
      bus.active   <= 1'b0;
      bus.cur_note <= 4'd0;
      bus.tick     <= 1'b0;
    end else begin
      pending  <= (bus.enable && note_ok) ? bus.note : 4'd0;
      bus.tick <= 1'b0;
      case (state)
        IDLE: begin
          if (pending != 4'd0) begin
            state        <= PLAY;
            bus.active   <= 1'b1;
            bus.cur_note <= pending;
            counter      <= reload;
            bus.FREQ     <= 1'b1;
            bus.tick     <= 1'b1;
          end
        end
        PLAY: begin
          if (counter != '0) begin
            counter <= counter - CNT_W'(1);
          end else if (pending != 4'd0) begin
            // Same or new note: either way reload from pending and toggle.
            bus.cur_note <= pending;
            counter      <= reload;
            bus.FREQ     <= ~bus.FREQ;
            bus.tick     <= 1'b1;
          end else begin
            // Stop: a finished high phase still falls (and ticks); a finished
            // low phase just stays low, so no partial high pulse appears.
            state        <= IDLE;
            bus.active   <= 1'b0;
            bus.cur_note <= 4'd0;
            bus.FREQ     <= 1'b0;
            bus.tick     <= bus.FREQ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_note_tone_gen.sv
// tb/tb_note_tone_gen.sv - self-checking bench for note_tone_gen with a phase-length reference model
module tb_note_tone_gen;
  localparam int CLK_HZ = 10000;
  localparam int CNT_W  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  note_tone_gen_if bus();

  note_tone_gen #(.CLK_HZ(CLK_HZ), .CNT_W(CNT_W)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: tracks the tone as phases of a given length and age,
  // with lengths computed straight from the note frequencies.
  function automatic int tone_hz(input int n);
    case (n)
      1: return 262;
      2: return 294;
      3: return 330;
      4: return 349;
      5: return 392;
      6: return 440;
      7: return 494;
      8: return 523;
      default: return 0;
    endcase
  endfunction

  function automatic int phase_len(input int n, input int o);
    int h;
    h = (CLK_HZ / (2 * tone_hz(n))) >> o;
    return (h < 1) ? 1 : h;
  endfunction

  int m_pend, m_oct, m_freq, m_act, m_note, m_tick, m_len, m_age;
  int m_next, m_next_oct;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pend = 0; m_oct = 0; m_freq = 0; m_act = 0;
      m_note = 0; m_tick = 0; m_len = 0; m_age = 0;
    end else begin
      m_next = (bus.enable && tone_hz(int'(bus.note)) != 0) ? int'(bus.note) : 0;
`ifdef TONE_OCTAVE_EN
      m_next_oct = int'(bus.oct);
`else
      m_next_oct = 0;
`endif
      m_tick = 0;
      if (m_act == 0) begin
        if (m_pend != 0) begin
          m_act = 1; m_note = m_pend; m_freq = 1; m_tick = 1;
          m_len = phase_len(m_pend, m_oct); m_age = 1;
        end
      end else if (m_age < m_len) begin
        m_age++;
      end else if (m_pend != 0) begin
        m_freq = 1 - m_freq; m_tick = 1; m_note = m_pend;
        m_len = phase_len(m_pend, m_oct); m_age = 1;
      end else begin
        m_tick = m_freq; m_freq = 0; m_act = 0; m_note = 0;
      end
      m_pend = m_next;
      m_oct  = m_next_oct;
    end
  end

  always @(negedge clk) begin
    check("model_freq",     32'(bus.FREQ),     32'(m_freq));
    check("model_active",   32'(bus.active),   32'(m_act));
    check("model_cur_note", 32'(bus.cur_note), 32'(m_note));
    check("model_tick",     32'(bus.tick),     32'(m_tick));
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called on the first sample of a phase; returns how many cycles FREQ keeps that level.
  task automatic measure(output int len);
    logic lv;
    lv  = bus.FREQ;
    len = 0;
    while (bus.FREQ === lv && len < 200) begin
      @(negedge clk);
      len++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int len;
    int n;
    bus.note   = 4'd0;
    bus.enable = 1'b1;
`ifdef TONE_OCTAVE_EN
    bus.oct    = 2'd0;
`endif
    step(3);
    check("rst_freq",   32'(bus.FREQ),     0);
    check("rst_active", 32'(bus.active),   0);
    check("rst_note",   32'(bus.cur_note), 0);
    rst = 1'b0;

    // C held: 2-cycle start, 19-cycle half-periods
    bus.note = 4'd1;
    step(1); check("c_lat1", 32'(bus.FREQ), 0);
    step(1); check("c_lat2", 32'(bus.FREQ), 1);
    check("c_tick0",   32'(bus.tick),     1);
    check("c_active",  32'(bus.active),   1);
    check("c_curnote", 32'(bus.cur_note), 1);
    measure(len); check("c_high", 32'(len), 19);
    check("c_tick1", 32'(bus.tick), 1);
    measure(len); check("c_low", 32'(len), 19);

    // Switch to E mid half-period
    step(5); bus.note = 4'd3;
    measure(len); check("ce_rest", 32'(len), 14);
    check("ce_curnote", 32'(bus.cur_note), 3);
    measure(len); check("e_half1", 32'(len), 15);
    measure(len); check("e_half2", 32'(len), 15);

    // A, then stop during a high phase
    bus.note = 4'd6;
    measure(len); check("ea_rest", 32'(len), 15);
    measure(len); check("a_half", 32'(len), 11);
    if (bus.FREQ == 1'b0) begin
      measure(len); check("a_half2", 32'(len), 11);
    end
    step(3); bus.note = 4'd0;
    measure(len); check("a_high_rest", 32'(len), 8);
    check("a_off_freq",   32'(bus.FREQ),     0);
    check("a_off_active", 32'(bus.active),   0);
    check("a_off_note",   32'(bus.cur_note), 0);
    check("a_off_tick",   32'(bus.tick),     1);
    step(20);
    check("a_silent_freq",   32'(bus.FREQ),   0);
    check("a_silent_active", 32'(bus.active), 0);

    // A, then stop during a low phase
    bus.note = 4'd6;
    step(2); check("a2_start", 32'(bus.FREQ), 1);
    measure(len); check("a2_high", 32'(len), 11);
    step(2); bus.note = 4'd0;
    step(8); check("a2_low_active", 32'(bus.active), 1);
    step(1);
    check("a2_end_active", 32'(bus.active), 0);
    check("a2_end_freq",   32'(bus.FREQ),   0);
    check("a2_end_tick",   32'(bus.tick),   0);

    // Invalid code, then C5
    bus.note = 4'd12;
    step(5);
    check("inv_freq",   32'(bus.FREQ),   0);
    check("inv_active", 32'(bus.active), 0);
    bus.note = 4'd8;
    step(1); check("c5_lat1", 32'(bus.FREQ), 0);
    step(1); check("c5_lat2", 32'(bus.FREQ), 1);
    measure(len); check("c5_half1", 32'(len), 9);
    measure(len); check("c5_half2", 32'(len), 9);

    // E, then enable drop and restore
    bus.note = 4'd3;
    measure(len); check("c5e_rest", 32'(len), 9);
    measure(len); check("en_e_half", 32'(len), 15);
    bus.enable = 1'b0;
    n = 0;
    while (bus.active == 1'b1 && n < 60) begin
      step(1);
      n++;
    end
    check("en_off_active", 32'(bus.active), 0);
    check("en_off_freq",   32'(bus.FREQ),   0);
    bus.enable = 1'b1;
    step(1); check("en_on_lat1", 32'(bus.FREQ), 0);
    step(1); check("en_on_lat2", 32'(bus.FREQ), 1);
    check("en_on_note", 32'(bus.cur_note), 3);

    // Asynchronous reset mid-high
    step(3);
    #2 rst = 1'b1;
    #1;
    check("arst_freq",   32'(bus.FREQ),     0);
    check("arst_active", 32'(bus.active),   0);
    check("arst_note",   32'(bus.cur_note), 0);
    check("arst_tick",   32'(bus.tick),     0);
    step(1);
    bus.note = 4'd1;
    step(1); rst = 1'b0;
    step(1); check("arst_lat1", 32'(bus.FREQ), 0);
    step(1); check("arst_lat2", 32'(bus.FREQ), 1);
    check("arst_curnote", 32'(bus.cur_note), 1);

`ifdef TONE_OCTAVE_EN
    bus.oct = 2'd1;
    measure(len); check("oct_rest", 32'(len), 19);
    measure(len); check("oct_half", 32'(len), 9);
    bus.oct = 2'd0;
`endif

    // Randomized stimulus against the model, with occasional async resets
    for (int s = 0; s < 250; s++) begin
      bus.note   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 8));
      bus.enable = ($urandom_range(0, 7) != 0);
`ifdef TONE_OCTAVE_EN
      bus.oct    = 2'($urandom_range(0, 3));
`endif
      if ($urandom_range(0, 39) == 0) begin
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      step($urandom_range(1, 50));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
